rv32_fetch: RTL

RV32_FETCH -- requirements
Module: rv32_fetch

---
 rtl/rv32_fetch.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rv32_fetch.sv
// RV32 instruction fetch stage. It has a one-entry skid buffer for downstream stalls,
// branch/trap redirect, and a misaligned-target fault slot.
//
// state    | meaning
// FETCH    | bus read of fetch_pc in flight; a response goes to the outputs or to the buffer
// BUFFERED | one instruction is parked because downstream stalled; no bus read
// FAULT    | a misaligned redirect target is presented; held until the next redirect
module rv32_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_pc_in,
    input  logic        trap_in,
    input  logic [31:0] trap_pc_in,
    output logic        instr_read_out,
    output logic [31:0] instr_address_out,
    input  logic        instr_ready_in,
    input  logic [31:0] instr_read_value_in,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid_out,
    output logic        misaligned_out,
    output logic        flush_out
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {FETCH, BUFFERED, FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;
    logic        flush_q, flush_d;

    logic        redirect;
    logic [31:0] target;

    assign redirect = trap_in | branch_taken_in;
    assign target   = trap_in ? trap_pc_in : branch_pc_in;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        mis_d       = mis_q;
        flush_d     = 1'b0;
        if (redirect) begin
            // A redirect wins over any bus response, buffered entry and stall.
            flush_d = 1'b1;
            if (target[1]) begin
                state_d = FAULT;
                pc_d    = target;
                instr_d = NOP;
                valid_d = 1'b1;
                mis_d   = 1'b1;
            end else begin
                state_d    = FETCH;
                fetch_pc_d = target;
                valid_d    = 1'b0;
                mis_d      = 1'b0;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (instr_ready_in) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (stall_in) begin
                            buf_pc_d    = fetch_pc_q;
                            buf_instr_d = instr_read_value_in;
                            state_d     = BUFFERED;
                        end else begin
                            pc_d    = fetch_pc_q;
                            instr_d = instr_read_value_in;
                            valid_d = 1'b1;
                            mis_d   = 1'b0;
                        end
                    end else if (!stall_in) begin
                        valid_d = 1'b0;
                        mis_d   = 1'b0;
                    end
                end
                BUFFERED: begin
                    if (!stall_in) begin
                        pc_d    = buf_pc_q;
                        instr_d = buf_instr_q;
                        valid_d = 1'b1;
                        mis_d   = 1'b0;
                        state_d = FETCH;
                    end
                end
                FAULT: ;
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            fetch_pc_q  <= RESET_VECTOR;
            buf_pc_q    <= 32'h0;
            buf_instr_q <= NOP;
            pc_q        <= 32'h0;
            instr_q     <= NOP;
            valid_q     <= 1'b0;
            mis_q       <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            mis_q       <= mis_d;
            flush_q     <= flush_d;
        end
    end

    assign instr_read_out    = (state_q == FETCH) & ~reset;
    assign instr_address_out = fetch_pc_q;
    assign pc_out            = pc_q;
    assign instr_out         = instr_q;
    assign valid_out         = valid_q;
    assign misaligned_out    = mis_q;
    assign flush_out         = flush_q;

endmodule
